// File: rtl/lcd_timing_pkg.sv
// ============================================================================
// Module   : lcd_timing_pkg
// Brief    : Default 480x272 panel timing and the shared coordinate width.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_timing_pkg;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BP     = 2;
    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BP     = 2;

    localparam int LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;
    localparam int LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

    // Coordinate width shared with the renderer; totals must fit in it.
    localparam int LCD_COORD_W  = 11;

    typedef logic [LCD_COORD_W-1:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/lcd_axis_cnt.sv
// ============================================================================
// Module   : lcd_axis_cnt
// Brief    : Enabled modulo-TOTAL counter with a wrap pulse on its last count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_axis_cnt
    import lcd_timing_pkg::*;
#(
    parameter int TOTAL = LCD_H_TOTAL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap
);

    localparam coord_t c_last = coord_t'(TOTAL - 1);

    coord_t r_count;

    assign wrap  = en && (r_count == c_last);
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + coord_t'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// ============================================================================
// Module   : lcd_timing_gen
// Brief    : Raster timing generator (syncs, DEN, X/Y); registered outputs.
//            Define LCD_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic   clk,
    input  logic   rst_in,
    output logic   hsync,
    output logic   vsync,
    output logic   den,
    output coord_t x,
    output coord_t y,
    output logic   frame_start
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t c_h_active = coord_t'(H_ACTIVE);
    localparam coord_t c_hs_start = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_hs_end   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t c_v_active = coord_t'(V_ACTIVE);
    localparam coord_t c_vs_start = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_vs_end   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t w_hcnt;
    coord_t w_vcnt;
    logic   w_h_wrap;
    logic   w_v_wrap;

    lcd_axis_cnt #(.TOTAL(H_TOTAL)) u_hcnt (
        .clk   (clk),
        .rst   (rst_in),
        .en    (1'b1),
        .count (w_hcnt),
        .wrap  (w_h_wrap)
    );

    lcd_axis_cnt #(.TOTAL(V_TOTAL)) u_vcnt (
        .clk   (clk),
        .rst   (rst_in),
        .en    (w_h_wrap),
        .count (w_vcnt),
        .wrap  (w_v_wrap)
    );

    // Window decode of the current counter position, registered below so
    // every output moves on the same edge.
    logic w_den;
    logic w_hs_win;
    logic w_vs_win;
    logic w_frame_start;

    assign w_den         = (w_hcnt < c_h_active) && (w_vcnt < c_v_active);
    assign w_hs_win      = (w_hcnt >= c_hs_start) && (w_hcnt < c_hs_end);
    assign w_vs_win      = (w_vcnt >= c_vs_start) && (w_vcnt < c_vs_end);
    assign w_frame_start = (w_hcnt == '0) && (w_vcnt == '0);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            den         <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= w_hs_win ? HS_POL : ~HS_POL;
            vsync       <= w_vs_win ? VS_POL : ~VS_POL;
            den         <= w_den;
            x           <= w_den ? w_hcnt : '0;
            y           <= w_den ? w_vcnt : '0;
            frame_start <= w_frame_start;
        end
    end

`ifdef LCD_TIMING_FRAME_CNT_EN
    // Counts on the edge that registers frame_start, so it reads 1 during
    // the first pulse after reset.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            frame_cnt <= '0;
        end else if (w_frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    // Frame counter absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
// ============================================================================
// Module   : tb_lcd_timing_gen
// Brief    : Small-raster bench for lcd_timing_gen (both sync polarities).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        hsync, vsync, den, fs;
    logic [10:0] x, y;
    logic        hsync_p, vsync_p, den_p, fs_p;
    logic [10:0] x_p, y_p;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] fcnt, fcnt_p;
`endif

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_in(rst), .hsync(hsync), .vsync(vsync), .den(den),
        .x(x), .y(y), .frame_start(fs)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(fcnt)
`endif
    );

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst_in(rst), .hsync(hsync_p), .vsync(vsync_p), .den(den_p),
        .x(x_p), .y(y_p), .frame_start(fs_p)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(fcnt_p)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: linear raster index. 'shown' is the position the outputs display.
    int pos       = 0;
    int shown     = 0;
    bit shown_rst = 1'b1;
    int exp_fcnt  = 0;

    always @(posedge clk) begin
        if (rst) begin
            pos       <= 0;
            shown_rst <= 1'b1;
            exp_fcnt  <= 0;
        end else begin
            shown     <= pos;
            shown_rst <= 1'b0;
            pos       <= (pos + 1) % FRAME;
            if (pos == 0) exp_fcnt <= (exp_fcnt + 1) % 65536;
        end
    end

    function automatic logic [25:0] exp_vec(input int p, input bit r, input bit pol);
        int h, v;
        logic e_den, e_hs, e_vs, e_fs;
        logic [10:0] e_x, e_y;
        if (r) return {~pol, ~pol, 1'b0, 11'd0, 11'd0, 1'b0};
        h     = p % HT;
        v     = p / HT;
        e_den = (h < HA) && (v < VA);
        e_x   = e_den ? 11'(h) : 11'd0;
        e_y   = e_den ? 11'(v) : 11'd0;
        e_hs  = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
        e_vs  = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
        e_fs  = (p == 0);
        return {e_hs, e_vs, e_den, e_x, e_y, e_fs};
    endfunction

    always @(negedge clk) begin
        logic [25:0] e0, a0, e1, a1;
        e0 = exp_vec(shown, shown_rst, 1'b0);
        a0 = {hsync, vsync, den, x, y, fs};
        e1 = exp_vec(shown, shown_rst, 1'b1);
        a1 = {hsync_p, vsync_p, den_p, x_p, y_p, fs_p};
        vectors++;
        if (a0 !== e0) begin
            miscompares++;
            $display("FAIL model_pol0 pos=%0d act=%h exp=%h", shown, a0, e0);
        end
        vectors++;
        if (a1 !== e1) begin
            miscompares++;
            $display("FAIL model_pol1 pos=%0d act=%h exp=%h", shown, a1, e1);
        end
`ifdef LCD_TIMING_FRAME_CNT_EN
        vectors++;
        if (fcnt !== 16'(exp_fcnt) || fcnt_p !== 16'(exp_fcnt)) begin
            miscompares++;
            $display("FAIL model_fcnt act=%0d/%0d exp=%0d", fcnt, fcnt_p, exp_fcnt);
        end
`endif
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    initial begin
        int ex_x[8]   = '{0, 1, 2, 3, 0, 0, 0, 0};
        int ex_den[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int ex_hs[8]  = '{1, 1, 1, 1, 1, 0, 0, 1};
        int hs_p_cnt, vs_low, den_cnt, fs_cnt, gap;
        bit found;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_den", den, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_fs", fs, 0);
        chk("rst_hsync_p", hsync_p, 0);
        chk("rst_vsync_p", vsync_p, 0);
        rst = 1'b0;

        hs_p_cnt = 0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            chk("line_x", x, ex_x[e]);
            chk("line_den", den, ex_den[e]);
            chk("line_hsync", hsync, ex_hs[e]);
            if (hsync_p) hs_p_cnt++;
            if (e == 0) begin
                chk("first_fs", fs, 1);
                chk("first_y", y, 0);
`ifdef LCD_TIMING_FRAME_CNT_EN
                chk("first_fcnt", fcnt, 1);
`endif
            end
        end
        chk("hsync_p_width", hs_p_cnt, HS);

        vs_low = 0; den_cnt = 0; fs_cnt = 0;
        for (int e = 0; e < FRAME; e++) begin
            @(negedge clk);
            if (!vsync) vs_low++;
            if (den) den_cnt++;
            if (fs) fs_cnt++;
            if (den && y >= 11'(VA)) chk("den_in_vblank", 1, 0);
        end
        chk("frame_vsync_low", vs_low, 8);
        chk("frame_den_cnt", den_cnt, 12);
        chk("frame_fs_cnt", fs_cnt, 1);

        // Stop on counter position (2,1): outputs then show index 9.
        found = 1'b0;
        for (int e = 0; e < 2 * FRAME && !found; e++) begin
            @(negedge clk);
            if (!shown_rst && shown == 9) found = 1'b1;
        end
        chk("reach_pos_2_1", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_den", den, 0);
        chk("midrst_fs", fs, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_fs", fs, 1);
        chk("restart_den", den, 1);
        chk("restart_x", x, 0);
        chk("restart_y", y, 0);
        gap = 0;
        found = 1'b0;
        for (int e = 0; e < 2 * FRAME && !found; e++) begin
            @(negedge clk);
            gap++;
            if (fs) found = 1'b1;
        end
        chk("fs_period", gap, FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Raster timing generator for the 480×272 RGB LCD. Free-running horizontal and vertical counters produce HSYNC, VSYNC, the data-enable strobe and the active-area pixel coordinates. These drive the panel sync pins and feed the DEN/X/Y inputs of the pixel-colour stage (pong renderer) directly upstream of it. All outputs are registered and mutually aligned, so the renderer's colour register lands one cycle later, aligned to a one-cycle-delayed copy of the syncs.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, HSYNC width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame (must equal the renderer's height parameter)
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VSYNC width (lines)
- V_BP, 2, vertical back porch (lines)
- HS_POL, 0, HSYNC asserted level
- VS_POL, 0, VSYNC asserted level
- CLK  in  1  pixel clock; all logic on rising edge
- RST_IN  in  1  synchronous, active-high reset
- HSYNC  out  1  horizontal sync, level HS_POL when asserted
- VSYNC  out  1  vertical sync, level VS_POL when asserted
- DEN  out  1  high inside the active area
- X  out  11  pixel column 0..H_ACTIVE-1 while DEN, else 0
- Y  out  11  pixel row 0..V_ACTIVE-1 while DEN, else 0
- FRAME_START  out  1  one-cycle pulse coincident with DEN at (0,0)
- FRAME_CNT  out  16  frames started since reset (present only with the macro; see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 2048.
- hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments only on the hcnt wrap and wraps 0 after V_TOTAL-1.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. The vertical order is the same, in lines.
- DEN = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
- HSYNC asserts in the horizontal sync window on every line, including vertical blanking.
- VSYNC asserts for whole lines in the vertical sync window. It changes only on line boundaries (hcnt=0).
- FRAME_START = (hcnt==0 && vcnt==0).
- Width rule: compare in 11 bits. Outside DEN, X and Y are forced to 0, not to the counter values.
- RST_IN high: hcnt=vcnt=0. Outputs: DEN=0, X=Y=0, FRAME_START=0, HSYNC=!HS_POL, VSYNC=!VS_POL, FRAME_CNT=0.
- Reset asserted mid-frame aborts the frame on the next edge. There is no partial-frame recovery.

## Timing
- Outputs are registered from a decode of the current counter values. Output latency is 1 cycle from the counter state.
- On the first edge with RST_IN low, the outputs show position (0,0): DEN=1, X=0, Y=0, FRAME_START=1. The counters move to (1,0) on the same edge.
- In general, k edges after reset release, the outputs show raster position k-1, wrapped modulo H_TOTAL·V_TOTAL.
- HSYNC, VSYNC, DEN, X and Y always change on the same edge. There is no skew between them.
- Frame period is H_TOTAL·V_TOTAL clocks (525·286 = 150150 with defaults). There are no stalls and no handshake.

## Configuration
- LCD_TIMING_FRAME_CNT_EN defined:
  - adds the FRAME_CNT port, a 16-bit counter;
  - it increments on the same edge FRAME_START is registered high, so FRAME_CNT reads 1 during the first FRAME_START pulse after reset;
  - it wraps from 0xFFFF to 0;
  - it is reset to 0.
- Macro undefined: the FRAME_CNT port and its counter do not exist, and all other behaviour is identical.

## Structure
- lcd_timing_pkg holds:
  - default timing constants (LCD_H_ACTIVE, LCD_V_ACTIVE, porch and sync widths);
  - the derived H_TOTAL/V_TOTAL;
  - the 11-bit coordinate width constant, shared with the renderer.
- One sub-module, lcd_axis_cnt: a parameterised wrap counter with an enable input and a wrap-pulse output. It is instantiated twice: horizontal with enable tied high, and vertical enabled by the horizontal wrap pulse.
- Window decode and output registers live in the top level.

## Test plan
Small bench parameters for scenarios 1–4: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); HS_POL=VS_POL=0.
1. Hold RST_IN high for 3 edges -> DEN=0, X=Y=0, HSYNC=VSYNC=1, FRAME_START=0. On the first edge after release: DEN=1, X=0, Y=0, FRAME_START=1.
2. Free-run one line -> X reads 0,1,2,3 with DEN=1; then DEN=0 for 4 edges with X=0; HSYNC is low on output edges 6 and 7 (positions 5,6).
3. Free-run one frame -> DEN is never high on lines 3–5; VSYNC is low for exactly 8 edges (line 4); FRAME_START is high once every 48 edges.
4. Assert RST_IN for 1 edge at position (2,1), then release -> the next output is (0,0) with FRAME_START=1, and the 48-edge period restarts.
5. Default parameters with LCD_TIMING_FRAME_CNT_EN defined -> FRAME_START pulses are 150150 edges apart; DEN-high count per frame is 130560; FRAME_CNT reads 1 after the first pulse and 3 after the third.
6. Default parameters with HS_POL=1, VS_POL=1 -> reset shows HSYNC=VSYNC=0; HSYNC is high for exactly 41 consecutive edges per line.
